// File: rtl/video_frame_dma_sequencer_pkg.sv
// Shared definitions for the video frame DMA sequencer.
// State encodings and default command sizing.
package video_frame_dma_sequencer_pkg;

    localparam int cDefChunkLen   = 256;
    localparam int cDefMaxRdBurst = 4;

    localparam logic [2:0] cStIdle    = 3'd0;
    localparam logic [2:0] cStRdIssue = 3'd1;
    localparam logic [2:0] cStRdWait  = 3'd2;
    localparam logic [2:0] cStWrIssue = 3'd3;
    localparam logic [2:0] cStWrWait  = 3'd4;

    typedef enum logic [2:0] {
        sIdle    = cStIdle,
        sRdIssue = cStRdIssue,
        sRdWait  = cStRdWait,
        sWrIssue = cStWrIssue,
        sWrWait  = cStWrWait
    } seqState_t;

endpackage

// File: rtl/video_frame_dma_sequencer_chunk_len_calc.sv
// Chunk length for one DMA direction:
// the smaller of the chunk limit and the words left in the frame.
module video_frame_dma_sequencer_chunk_len_calc #(
    parameter int pWidth    = 19,
    parameter int pChunkLen = 256
) (
    input  logic [pWidth-1:0] iFrameWords,
    input  logic [pWidth-1:0] iOffset,
    output logic [pWidth-1:0] oLen
);

    localparam logic [pWidth-1:0] cChunk = pWidth'(pChunkLen);

    logic [pWidth-1:0] remain;

    assign remain = iFrameWords - iOffset;
    assign oLen   = (remain > cChunk) ? cChunk : remain;

endmodule

// File: rtl/video_frame_dma_sequencer.sv
// Double-buffered video DMA sequencer: read-priority arbitration
// with guaranteed write slots and frame-end buffer swapping.
module video_frame_dma_sequencer
    import video_frame_dma_sequencer_pkg::*;
#(
    parameter int pMemAdrsWidth = 19,
    parameter int pChunkLen     = cDefChunkLen,
    parameter int pMaxRdBurst   = cDefMaxRdBurst
) (
    input  logic                     iClk,
    input  logic                     iRst,
    input  logic                     iEn,
    input  logic [pMemAdrsWidth-1:0] iBufBase0,
    input  logic [pMemAdrsWidth-1:0] iBufBase1,
    input  logic [pMemAdrsWidth-1:0] iFrameWords,
    input  logic                     iFrameEnd,
    input  logic                     iRdReq,
    input  logic                     iWrReady,
    input  logic                     iDmaDone,
    output logic [pMemAdrsWidth-1:0] oDmaWAdrs,
    output logic [pMemAdrsWidth-1:0] oDmaRAdrs,
    output logic [pMemAdrsWidth-1:0] oDmaWLen,
    output logic [pMemAdrsWidth-1:0] oDmaRLen,
    output logic                     oDmaEn,
    output logic                     oFront,
    output logic                     oFrameSwap,
    output logic                     oBusy
);

    localparam int W       = pMemAdrsWidth;
    localparam int cBurstW = $clog2(pMaxRdBurst + 1);
    localparam logic [cBurstW-1:0] cMaxBurst = cBurstW'(pMaxRdBurst);

    seqState_t          state;
    logic               front;
    logic               fePending;
    logic [W-1:0]       rdOffset;
    logic [W-1:0]       wrOffset;
    logic [cBurstW-1:0] burstCnt;

    logic         frameDone;
    logic         swapNow;
    logic         effFront;
    logic [W-1:0] effRdOff;
    logic [W-1:0] effWrOff;
    logic [W-1:0] frontBase;
    logic [W-1:0] backBase;
    logic [W-1:0] rdLenNext;
    logic [W-1:0] wrLenNext;
    logic         wrElig;
    logic         rdGo;
    logic [W:0]   rdSum;
    logic [W:0]   wrSum;

    // Pending frame end is folded in before arbitration in IDLE.
    assign frameDone = (wrOffset == iFrameWords);
    assign swapNow   = fePending && frameDone;
    assign effFront  = swapNow ? ~front : front;
    assign effRdOff  = fePending ? '0 : rdOffset;
    assign effWrOff  = swapNow ? '0 : wrOffset;
    assign frontBase = effFront ? iBufBase1 : iBufBase0;
    assign backBase  = effFront ? iBufBase0 : iBufBase1;

    assign wrElig = iWrReady && (effWrOff < iFrameWords);
    assign rdGo   = iRdReq && ((burstCnt < cMaxBurst) || !wrElig);

    assign rdSum = {1'b0, rdOffset} + {1'b0, oDmaRLen};
    assign wrSum = {1'b0, wrOffset} + {1'b0, oDmaWLen};

    assign oFront = front;

    video_frame_dma_sequencer_chunk_len_calc #(
        .pWidth    (W),
        .pChunkLen (pChunkLen)
    ) uRdLen (
        .iFrameWords (iFrameWords),
        .iOffset     (effRdOff),
        .oLen        (rdLenNext)
    );

    video_frame_dma_sequencer_chunk_len_calc #(
        .pWidth    (W),
        .pChunkLen (pChunkLen)
    ) uWrLen (
        .iFrameWords (iFrameWords),
        .iOffset     (effWrOff),
        .oLen        (wrLenNext)
    );

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state      <= sIdle;
            front      <= 1'b0;
            fePending  <= 1'b0;
            rdOffset   <= '0;
            wrOffset   <= '0;
            burstCnt   <= '0;
            oDmaWAdrs  <= '0;
            oDmaRAdrs  <= '0;
            oDmaWLen   <= '0;
            oDmaRLen   <= '0;
            oDmaEn     <= 1'b0;
            oFrameSwap <= 1'b0;
            oBusy      <= 1'b0;
        end else begin
            oDmaEn     <= 1'b0;
            oFrameSwap <= 1'b0;
            if (iFrameEnd) begin
                fePending <= 1'b1;
            end
            unique case (state)
                sIdle: begin
                    if (!iEn) begin
                        rdOffset <= '0;
                        wrOffset <= '0;
                    end else begin
                        if (fePending) begin
                            fePending <= iFrameEnd;
                            rdOffset  <= '0;
                            if (frameDone) begin
                                front      <= ~front;
                                wrOffset   <= '0;
                                oFrameSwap <= 1'b1;
                            end
                        end
                        if (rdGo) begin
                            state     <= sRdIssue;
                            oDmaEn    <= 1'b1;
                            oBusy     <= 1'b1;
                            oDmaRAdrs <= frontBase + effRdOff;
                            oDmaRLen  <= rdLenNext;
                            oDmaWAdrs <= '0;
                            oDmaWLen  <= '0;
                        end else if (wrElig) begin
                            state     <= sWrIssue;
                            oDmaEn    <= 1'b1;
                            oBusy     <= 1'b1;
                            oDmaWAdrs <= backBase + effWrOff;
                            oDmaWLen  <= wrLenNext;
                            oDmaRAdrs <= '0;
                            oDmaRLen  <= '0;
                        end
                    end
                end
                sRdIssue: begin
                    if (burstCnt < cMaxBurst) begin
                        burstCnt <= burstCnt + cBurstW'(1);
                    end
                    state <= sRdWait;
                end
                sRdWait: begin
                    if (iDmaDone) begin
                        rdOffset  <= (rdSum >= {1'b0, iFrameWords})
                                   ? '0 : rdSum[W-1:0];
                        state     <= sIdle;
                        oBusy     <= 1'b0;
                        oDmaRAdrs <= '0;
                        oDmaRLen  <= '0;
                    end
                end
                sWrIssue: begin
                    burstCnt <= '0;
                    state    <= sWrWait;
                end
                sWrWait: begin
                    if (iDmaDone) begin
                        wrOffset  <= (wrSum >= {1'b0, iFrameWords})
                                   ? iFrameWords : wrSum[W-1:0];
                        state     <= sIdle;
                        oBusy     <= 1'b0;
                        oDmaWAdrs <= '0;
                        oDmaWLen  <= '0;
                    end
                end
                default: state <= sIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_video_frame_dma_sequencer.sv
// Scoreboard bench for the video frame DMA sequencer.
// Expected commands are queued per scenario and checked as issued.
module tb_video_frame_dma_sequencer;

    localparam int W = 19;

    typedef struct packed {
        logic         wr;
        logic [W-1:0] adrs;
        logic [W-1:0] len;
    } cmd_t;

    cmd_t expQ[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   swapCount  = 0;
    logic feWithDone = 1'b0;

    logic         iClk = 1'b0;
    logic         iRst = 1'b1;
    logic         iEn = 1'b0;
    logic [W-1:0] iBufBase0 = 19'h00000;
    logic [W-1:0] iBufBase1 = 19'h10000;
    logic [W-1:0] iFrameWords = 19'd1000;
    logic         iFrameEnd = 1'b0;
    logic         iRdReq = 1'b0;
    logic         iWrReady = 1'b0;
    logic         iDmaDone = 1'b0;
    logic [W-1:0] oDmaWAdrs;
    logic [W-1:0] oDmaRAdrs;
    logic [W-1:0] oDmaWLen;
    logic [W-1:0] oDmaRLen;
    logic         oDmaEn;
    logic         oFront;
    logic         oFrameSwap;
    logic         oBusy;

    video_frame_dma_sequencer dut (
        .iClk        (iClk),
        .iRst        (iRst),
        .iEn         (iEn),
        .iBufBase0   (iBufBase0),
        .iBufBase1   (iBufBase1),
        .iFrameWords (iFrameWords),
        .iFrameEnd   (iFrameEnd),
        .iRdReq      (iRdReq),
        .iWrReady    (iWrReady),
        .iDmaDone    (iDmaDone),
        .oDmaWAdrs   (oDmaWAdrs),
        .oDmaRAdrs   (oDmaRAdrs),
        .oDmaWLen    (oDmaWLen),
        .oDmaRLen    (oDmaRLen),
        .oDmaEn      (oDmaEn),
        .oFront      (oFront),
        .oFrameSwap  (oFrameSwap),
        .oBusy       (oBusy)
    );

    always #5 iClk = ~iClk;

    always @(negedge iClk) begin
        if (oFrameSwap) swapCount++;
    end

    function automatic cmd_t mk(input logic wr, input int adrs, input int len);
        cmd_t c;
        c.wr   = wr;
        c.adrs = W'(adrs);
        c.len  = W'(len);
        return c;
    endfunction

    task automatic applyReset();
        iRst = 1'b1;
        iEn = 1'b1;
        iRdReq = 1'b0;
        iWrReady = 1'b0;
        iDmaDone = 1'b0;
        iFrameEnd = 1'b0;
        repeat (3) @(negedge iClk);
        iRst = 1'b0;
    endtask

    task automatic pulseFrameEnd();
        iFrameEnd = 1'b1;
        @(negedge iClk);
        iFrameEnd = 1'b0;
        repeat (3) @(negedge iClk);
    endtask

    // Waits for each command strobe, checks it, then completes it.
    task automatic runCmds(input int n);
        cmd_t         exp;
        logic [W-1:0] gA, gL, gO;
        int           waitCyc;
        for (int i = 0; i < n; i++) begin
            waitCyc = 0;
            @(negedge iClk);
            while (!oDmaEn && waitCyc < 50) begin
                @(negedge iClk);
                waitCyc++;
            end
            compared++;
            if (!oDmaEn || expQ.size() == 0) begin
                mismatched++;
                $display("FAIL cmd_timeout: strobe=%0b queued=%0d required strobe with queued cmd",
                         oDmaEn, expQ.size());
                return;
            end
            exp = expQ.pop_front();
            gA = exp.wr ? oDmaWAdrs : oDmaRAdrs;
            gL = exp.wr ? oDmaWLen : oDmaRLen;
            gO = exp.wr ? oDmaRLen : oDmaWLen;
            if (gA !== exp.adrs || gL !== exp.len || gO !== '0 || oBusy !== 1'b1) begin
                mismatched++;
                $display("FAIL cmd wr=%0b: got adrs=%h len=%0d otherLen=%0d busy=%0b, required adrs=%h len=%0d otherLen=0 busy=1",
                         exp.wr, gA, gL, gO, oBusy, exp.adrs, exp.len);
            end
            @(negedge iClk);
            compared++;
            if (oDmaEn !== 1'b0 || oBusy !== 1'b1 ||
                (exp.wr ? oDmaWAdrs : oDmaRAdrs) !== gA ||
                (exp.wr ? oDmaWLen : oDmaRLen) !== gL) begin
                mismatched++;
                $display("FAIL cmd_hold: en=%0b busy=%0b, required en=0 busy=1 with stable adrs=%h len=%0d",
                         oDmaEn, oBusy, gA, gL);
            end
            iDmaDone = 1'b1;
            iFrameEnd = feWithDone;
            @(negedge iClk);
            iDmaDone = 1'b0;
            iFrameEnd = 1'b0;
            compared++;
            if (oBusy !== 1'b0) begin
                mismatched++;
                $display("FAIL done_to_idle: busy=%0b required 0", oBusy);
            end
        end
    endtask

    task automatic test_reset();
        iRst = 1'b1;
        repeat (3) @(negedge iClk);
        compared++;
        if ({oDmaWAdrs, oDmaRAdrs, oDmaWLen, oDmaRLen, oDmaEn, oFront, oFrameSwap, oBusy} !== '0) begin
            mismatched++;
            $display("FAIL reset_outputs: wa=%h ra=%h wl=%0d rl=%0d en=%0b front=%0b swap=%0b busy=%0b, required all 0",
                     oDmaWAdrs, oDmaRAdrs, oDmaWLen, oDmaRLen, oDmaEn, oFront, oFrameSwap, oBusy);
        end
    endtask

    task automatic test_read_wrap();
        applyReset();
        iRdReq = 1'b1;
        expQ.push_back(mk(1'b0, 'h00000, 256));
        expQ.push_back(mk(1'b0, 'h00100, 256));
        expQ.push_back(mk(1'b0, 'h00200, 256));
        expQ.push_back(mk(1'b0, 'h00300, 232));
        expQ.push_back(mk(1'b0, 'h00000, 256));
        runCmds(5);
        iRdReq = 1'b0;
    endtask

    task automatic test_arbitration();
        applyReset();
        iRdReq = 1'b1;
        iWrReady = 1'b1;
        for (int g = 0; g < 2; g++) begin
            expQ.push_back(mk(1'b0, 'h00000, 256));
            expQ.push_back(mk(1'b0, 'h00100, 256));
            expQ.push_back(mk(1'b0, 'h00200, 256));
            expQ.push_back(mk(1'b0, 'h00300, 232));
            expQ.push_back(mk(1'b1, 'h10000 + g * 256, 256));
        end
        runCmds(10);
        iRdReq = 1'b0;
        iWrReady = 1'b0;
    endtask

    task automatic fillBackBuffer();
        iWrReady = 1'b1;
        expQ.push_back(mk(1'b1, 'h10000, 256));
        expQ.push_back(mk(1'b1, 'h10100, 256));
        expQ.push_back(mk(1'b1, 'h10200, 256));
        expQ.push_back(mk(1'b1, 'h10300, 232));
        runCmds(4);
        iWrReady = 1'b0;
    endtask

    task automatic test_frame_swap();
        int base;
        applyReset();
        fillBackBuffer();
        base = swapCount;
        pulseFrameEnd();
        compared++;
        if (swapCount - base !== 1 || oFront !== 1'b1) begin
            mismatched++;
            $display("FAIL frame_swap: swaps=%0d front=%0b, required swaps=1 front=1",
                     swapCount - base, oFront);
        end
        iRdReq = 1'b1;
        expQ.push_back(mk(1'b0, 'h10000, 256));
        runCmds(1);
        iRdReq = 1'b0;
        iWrReady = 1'b1;
        expQ.push_back(mk(1'b1, 'h00000, 256));
        runCmds(1);
        iWrReady = 1'b0;
    endtask

    task automatic test_no_swap();
        int base;
        applyReset();
        iRdReq = 1'b1;
        expQ.push_back(mk(1'b0, 'h00000, 256));
        runCmds(1);
        iRdReq = 1'b0;
        iWrReady = 1'b1;
        expQ.push_back(mk(1'b1, 'h10000, 256));
        expQ.push_back(mk(1'b1, 'h10100, 256));
        runCmds(2);
        iWrReady = 1'b0;
        base = swapCount;
        pulseFrameEnd();
        compared++;
        if (swapCount - base !== 0 || oFront !== 1'b0) begin
            mismatched++;
            $display("FAIL no_swap: swaps=%0d front=%0b, required swaps=0 front=0",
                     swapCount - base, oFront);
        end
        iRdReq = 1'b1;
        expQ.push_back(mk(1'b0, 'h00000, 256));
        runCmds(1);
        iRdReq = 1'b0;
        iWrReady = 1'b1;
        expQ.push_back(mk(1'b1, 'h10200, 256));
        runCmds(1);
        iWrReady = 1'b0;
    endtask

    task automatic test_fe_with_done();
        int base;
        applyReset();
        fillBackBuffer();
        base = swapCount;
        iRdReq = 1'b1;
        expQ.push_back(mk(1'b0, 'h00000, 256));
        feWithDone = 1'b1;
        runCmds(1);
        feWithDone = 1'b0;
        expQ.push_back(mk(1'b0, 'h10000, 256));
        runCmds(1);
        iRdReq = 1'b0;
        repeat (3) @(negedge iClk);
        compared++;
        if (swapCount - base !== 1 || oFront !== 1'b1) begin
            mismatched++;
            $display("FAIL fe_with_done: swaps=%0d front=%0b, required swaps=1 front=1",
                     swapCount - base, oFront);
        end
    endtask

    task automatic test_reset_mid_write();
        cmd_t exp;
        int   waitCyc;
        applyReset();
        iWrReady = 1'b1;
        expQ.push_back(mk(1'b1, 'h10000, 256));
        waitCyc = 0;
        @(negedge iClk);
        while (!oDmaEn && waitCyc < 50) begin
            @(negedge iClk);
            waitCyc++;
        end
        exp = expQ.pop_front();
        compared++;
        if (oDmaEn !== 1'b1 || oDmaWAdrs !== exp.adrs || oDmaWLen !== exp.len) begin
            mismatched++;
            $display("FAIL rst_mid_cmd: en=%0b adrs=%h len=%0d, required en=1 adrs=%h len=%0d",
                     oDmaEn, oDmaWAdrs, oDmaWLen, exp.adrs, exp.len);
        end
        @(negedge iClk);
        iRst = 1'b1;
        iWrReady = 1'b0;
        @(negedge iClk);
        compared++;
        if ({oDmaWAdrs, oDmaRAdrs, oDmaWLen, oDmaRLen, oDmaEn, oFront, oFrameSwap, oBusy} !== '0) begin
            mismatched++;
            $display("FAIL rst_mid_outputs: wa=%h wl=%0d en=%0b busy=%0b front=%0b, required all 0",
                     oDmaWAdrs, oDmaWLen, oDmaEn, oBusy, oFront);
        end
        iRst = 1'b0;
        iRdReq = 1'b1;
        expQ.push_back(mk(1'b0, 'h00000, 256));
        runCmds(1);
        iRdReq = 1'b0;
        iWrReady = 1'b1;
        expQ.push_back(mk(1'b1, 'h10000, 256));
        runCmds(1);
        iWrReady = 1'b0;
    endtask

    task automatic test_disable();
        applyReset();
        iRdReq = 1'b1;
        expQ.push_back(mk(1'b0, 'h00000, 256));
        runCmds(1);
        iEn = 1'b0;
        repeat (3) @(negedge iClk);
        compared++;
        if (oBusy !== 1'b0 || oDmaEn !== 1'b0) begin
            mismatched++;
            $display("FAIL disable_idle: busy=%0b en=%0b, required 0 0", oBusy, oDmaEn);
        end
        iEn = 1'b1;
        expQ.push_back(mk(1'b0, 'h00000, 256));
        runCmds(1);
        iRdReq = 1'b0;
    endtask

    initial begin
        test_reset();
        test_read_wrap();
        test_arbitration();
        test_frame_swap();
        test_no_swap();
        test_fe_with_done();
        test_reset_mid_write();
        test_disable();
        compared++;
        if (expQ.size() !== 0) begin
            mismatched++;
            $display("FAIL scoreboard_drain: %0d left, required 0", expQ.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/video_frame_dma_sequencer.md
Name: video_frame_dma_sequencer

Overview:
- Sequences the video DMA engine for double-buffered frame memory: it issues read chunks (memory to display FIFO) and write chunks (pixel generator to memory) as address/length/enable commands.
- Read has priority; writes are guaranteed a slot so the pixel generator cannot starve.
- Swaps the front and back buffers at frame end once the back buffer is completely written.
- Sits between the video register block and the video DMA unit, in the system clock domain.

Parameters:
pMemAdrsWidth, 19, memory word-address width
pChunkLen, 256, maximum words per DMA command
pMaxRdBurst, 4, consecutive read chunks allowed before a pending write is forced

Ports:
iClk  in  1  system clock
iRst  in  1  synchronous active-high reset
iEn  in  1  sequencer enable
iBufBase0  in  pMemAdrsWidth  base address of buffer 0
iBufBase1  in  pMemAdrsWidth  base address of buffer 1
iFrameWords  in  pMemAdrsWidth  words per frame, must be nonzero
iFrameEnd  in  1  one-cycle frame-end pulse, already synchronised to iClk
iRdReq  in  1  display FIFO below threshold, wants data
iWrReady  in  1  pixel source has data available
iDmaDone  in  1  one-cycle pulse: current DMA command completed
oDmaWAdrs  out  pMemAdrsWidth  write start address
oDmaRAdrs  out  pMemAdrsWidth  read start address
oDmaWLen  out  pMemAdrsWidth  write length, 0 on read commands
oDmaRLen  out  pMemAdrsWidth  read length, 0 on write commands
oDmaEn  out  1  one-cycle command strobe
oFront  out  1  index of the buffer currently displayed
oFrameSwap  out  1  one-cycle pulse when buffers swap
oBusy  out  1  a command is in flight

Behaviour:
- Reset values:
  - All outputs are 0; front = 0.
  - Read offset and write offset are 0; burst count is 0; frame-end pending flag is cleared.
- FSM states are IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE and WR_WAIT. The FSM is Moore and all outputs are registered.
- IDLE:
  - If iEn = 0: hold offsets at 0, keep front, stay in IDLE.
  - Otherwise, first apply any pending frame end (see below), then arbitrate in this order:
    - If a read is eligible (iRdReq = 1) and (burst count < pMaxRdBurst or no write is eligible): go to RD_ISSUE.
    - Else if a write is eligible: go to WR_ISSUE.
  - A write is eligible when iWrReady = 1 and write offset < iFrameWords.
- RD_ISSUE (one cycle):
  - oDmaEn = 1.
  - oDmaRAdrs = front base + read offset.
  - oDmaRLen = min(pChunkLen, iFrameWords − read offset).
  - Increment burst count, saturating at pMaxRdBurst; go to RD_WAIT.
- RD_WAIT: hold the address and length outputs stable. On iDmaDone, add the length to the read offset, wrapping to 0 when it reaches iFrameWords, then return to IDLE.
- WR_ISSUE / WR_WAIT:
  - Symmetric to the read path, using the back base (opposite of front) and the write offset.
  - Burst count is cleared on WR_ISSUE.
  - The write offset saturates at iFrameWords; it does not wrap.
- oBusy = 1 in every state except IDLE.
- Latency: at most 1 cycle from IDLE to oDmaEn, and 1 cycle from iDmaDone to IDLE.
- Frame end:
  - iFrameEnd in any state sets the pending flag.
  - The flag is consumed in IDLE, on the cycle after in-flight completion.
  - On consumption, read offset is set to 0.
  - If write offset == iFrameWords: toggle front, clear write offset, and pulse oFrameSwap for 1 cycle.
  - Otherwise front is unchanged, so the frame repeats.
- Simultaneous iDmaDone and iFrameEnd: the offset update happens first, and the pending flag is applied on the next IDLE cycle.
- iDmaDone in IDLE or an ISSUE state is ignored.
- Address arithmetic is modulo 2^pMemAdrsWidth; length arithmetic is unsigned at pMemAdrsWidth bits.
- iEn deasserted mid-command: finish the in-flight command, then IDLE resets offsets.
- iRst mid-command: immediate return to reset values; aborting the DMA is the DMA unit's own reset responsibility.

Decomposition:
- Shared video package holds:
  - FSM state encodings (3-bit localparams).
  - Default pChunkLen and pMaxRdBurst.
- Sub-module chunk_len_calc: combinational min(pChunkLen, frame − offset), instantiated once per direction.

Test Plan:
1. iFrameWords = 1000, bases 0x00000/0x10000, iRdReq = 1, iWrReady = 0.
   - Read commands at 0x00000/256, 0x00100/256, 0x00200/256, 0x00300/232.
   - Then wrap to 0x00000.
2. iRdReq = 1 and iWrReady = 1 continuously, pMaxRdBurst = 4.
   - Command order R,R,R,R,W,R,R,R,R,W.
   - First write at 0x10000 with length 256.
3. Complete 1000 write words, then pulse iFrameEnd.
   - oFrameSwap pulses once; oFront becomes 1.
   - Next read at 0x10000; next write at 0x00000.
4. iFrameEnd with write offset 512.
   - No swap; oFront unchanged; read offset becomes 0; write resumes at base + 512.
5. iFrameEnd coincident with iDmaDone during RD_WAIT.
   - Offset updated, then swap applied in IDLE.
   - No dropped frame end; exactly one oFrameSwap.
6. Assert iRst during WR_WAIT.
   - Next cycle: all outputs 0, front 0, offsets 0.
   - After release, the first read starts at 0x00000.
